// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data-memory port arbiter between the core load/store path and a host burst port
// Optional starvation guard: define DMEM_ARB_STARVE_GUARD_EN.
`timescale 1ns/1ps

module dmem_arbiter #(
    parameter int DATA_W    = 32,
    parameter int MAX_WAIT  = 8,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [DATA_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [DATA_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_last,
    output logic              host_gnt,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    typedef enum logic {
        ST_CORE = 1'b0,
        ST_HOST = 1'b1
    } state_t;

    // Out-of-range counter limits would silently break the 8-bit counters.
    if (MAX_WAIT < 1 || MAX_WAIT > 255 || MAX_BURST < 1 || MAX_BURST > 255) begin : g_param_check
        $error("dmem_arbiter: MAX_WAIT and MAX_BURST must be within 1..255");
    end

    state_t     state, state_nxt;
    logic [7:0] beat_cnt, beat_cnt_nxt;
    logic       host_acc;
    logic       burst_done;
    logic       starved;
    logic       host_take;

    assign host_acc   = (state == ST_HOST) && host_req;
    assign burst_done = host_acc && (host_last || (beat_cnt == 8'(MAX_BURST - 1)));
    assign host_take  = host_req && (!core_req || starved);
    assign core_rdata = mem_rd;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    logic [7:0] wait_cnt, wait_cnt_nxt;

    assign starved = (wait_cnt == 8'(MAX_WAIT));

    always_comb begin
        wait_cnt_nxt = 8'd0;
        if (state == ST_CORE && host_req && !host_take && !starved) begin
            wait_cnt_nxt = wait_cnt + 8'd1;
        end else if (state == ST_CORE && host_req && !host_take) begin
            wait_cnt_nxt = wait_cnt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 8'd0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
        end
    end
`else
    assign starved = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_CORE;
            beat_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = 8'd0;
        mem_addr     = core_addr;
        mem_wd       = core_wdata;
        mem_we       = core_req && core_we;
        core_stall   = 1'b0;
        host_gnt     = 1'b0;
        case (state)
            ST_CORE: begin
                if (host_take) begin
                    state_nxt = ST_HOST;
                end
            end
            ST_HOST: begin
                mem_addr   = host_addr;
                mem_wd     = host_wdata;
                mem_we     = host_req && host_we;
                core_stall = core_req;
                host_gnt   = 1'b1;
                // Release on last beat, burst cap, or an abandoned burst.
                if (!host_req || burst_done) begin
                    state_nxt = ST_CORE;
                end else begin
                    beat_cnt_nxt = beat_cnt + 8'd1;
                end
            end
            default: state_nxt = ST_CORE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            host_rdata  <= '0;
            host_rvalid <= 1'b0;
        end else begin
            host_rvalid <= host_acc && !host_we;
            if (host_acc && !host_we) begin
                host_rdata <= mem_rd;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
`timescale 1ns/1ps

module tb_dmem_arbiter;

    localparam int DW        = 32;
    localparam int MAX_WAIT  = 8;
    localparam int MAX_BURST = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_req, core_we;
    logic [DW-1:0] core_addr, core_wdata, core_rdata;
    logic          core_stall;
    logic          host_req, host_we, host_last;
    logic [DW-1:0] host_addr, host_wdata, host_rdata;
    logic          host_gnt, host_rvalid;
    logic          mem_we;
    logic [DW-1:0] mem_addr, mem_wd, mem_rd;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    logic [31:0] exp_q   [$];
    logic [31:0] mon_exp;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_W(DW), .MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_last(host_last), .host_gnt(host_gnt),
        .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    assign mem_rd = mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wd;

    always @(negedge clk) begin
        if (host_rvalid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rvalid_unexpected got=%h expected no read pending", host_rdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if (host_rdata !== mon_exp) begin
                    failures++;
                    $display("FAIL host_rdata got=%h expected=%h", host_rdata, mon_exp);
                end
            end
        end
    end

    // Drives a host burst beat by beat; enters and leaves at posedge+1.
    task automatic host_burst(input logic we, input logic [31:0] base, input logic [31:0] dbase,
                              input int n, input bit last_on_final,
                              output int first_run, output int total, output int first_gnt);
        int  i = 0;
        int  cyc = 0;
        bit  seen = 0;
        bit  dropped = 0;
        logic [31:0] a;
        first_run = 0;
        first_gnt = -1;
        while (i < n && cyc < 300) begin
            a          = base + 32'(4 * i);
            host_req   = 1'b1;
            host_we    = we;
            host_addr  = a;
            host_wdata = dbase + 32'(i);
            host_last  = last_on_final && (i == n - 1);
            @(negedge clk);
            if (host_gnt) begin
                if (!seen) first_gnt = cyc;
                seen = 1;
                if (!dropped) first_run++;
                if (we) ref_mem[a[9:2]] = host_wdata;
                else    exp_q.push_back(ref_mem[a[9:2]]);
                i++;
            end else if (seen) begin
                dropped = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        total     = i;
        host_req  = 1'b0;
        host_last = 1'b0;
        host_we   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        host_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (host_gnt !== 1'b0 || core_stall !== 1'b0 || host_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs gnt=%b stall=%b rvalid=%b expected 0 0 0", host_gnt, core_stall, host_rvalid);
        end
        checks++;
        if (host_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata got=%h expected=0", host_rdata);
        end
        reset = 1'b0;
        host_addr = 32'h0;
        @(negedge clk);
        checks++;
        if (host_gnt !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_gnt got=%b expected=0", host_gnt);
        end
        @(posedge clk); #1;
        core_req = 1'b1;
        @(negedge clk);
        checks++;
        if (host_gnt !== 1'b1 || core_stall !== 1'b1) begin
            failures++;
            $display("FAIL host_owner gnt=%b stall=%b expected 1 1", host_gnt, core_stall);
        end
        @(posedge clk); #1;
        checks++;
        if (host_rvalid !== 1'b1 || host_rdata !== ref_mem[0]) begin
            failures++;
            $display("FAIL pre_reset_read rvalid=%b rdata=%h expected 1 %h", host_rvalid, host_rdata, ref_mem[0]);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (host_gnt !== 1'b0 || core_stall !== 1'b0 || host_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL midburst_reset gnt=%b stall=%b rvalid=%b expected 0 0 0", host_gnt, core_stall, host_rvalid);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (host_gnt !== 1'b0 || core_stall !== 1'b0 || host_rvalid !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold gnt=%b stall=%b rvalid=%b expected 0 0 0", host_gnt, core_stall, host_rvalid);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        host_req = 1'b0;
        core_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_burst();
        int fr, tot, fg;
        host_burst(1'b1, 32'h100, 32'hA0, 4, 1'b1, fr, tot, fg);
        checks++;
        if (tot !== 4 || fr !== 4 || fg !== 1) begin
            failures++;
            $display("FAIL write_burst beats=%0d run=%0d first_gnt=%0d expected 4 4 1", tot, fr, fg);
        end
        @(negedge clk);
        checks++;
        if (host_gnt !== 1'b0) begin
            failures++;
            $display("FAIL write_burst_release gnt=%b expected=0", host_gnt);
        end
        @(posedge clk); #1;
        host_burst(1'b0, 32'h100, 32'h0, 1, 1'b1, fr, tot, fg);
        checks++;
        if (host_rvalid !== 1'b1 || host_rdata !== 32'hA0) begin
            failures++;
            $display("FAIL readback_0x100 rvalid=%b rdata=%h expected 1 000000a0", host_rvalid, host_rdata);
        end
        @(posedge clk); #1;
        checks++;
        if (host_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL rvalid_pulse got=%b expected=0", host_rvalid);
        end
        host_burst(1'b0, 32'h100, 32'h0, 4, 1'b1, fr, tot, fg);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_for_gnt(input int limit, output int gnt_cycle);
        gnt_cycle = -1;
        for (int c = 0; c < limit && gnt_cycle < 0; c++) begin
            @(negedge clk);
            if (host_gnt) begin
                gnt_cycle = c;
                exp_q.push_back(ref_mem[host_addr[9:2]]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_contention();
        int g;
        host_req = 1'b1; host_we = 1'b0; host_addr = 32'h104; host_last = 1'b1;
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10C;
        @(negedge clk);
        checks++;
        if (mem_addr !== 32'h10C || core_rdata !== 32'hA3 || host_gnt !== 1'b0) begin
            failures++;
            $display("FAIL core_load addr=%h rdata=%h gnt=%b expected 0000010c 000000a3 0", mem_addr, core_rdata, host_gnt);
        end
        @(posedge clk); #1;
`ifdef DMEM_ARB_STARVE_GUARD_EN
        wait_for_gnt(30, g);
        checks++;
        if (g !== MAX_WAIT) begin
            failures++;
            $display("FAIL starve_guard gnt_cycle=%0d expected=%0d", g + 1, MAX_WAIT + 1);
        end
`else
        wait_for_gnt(20, g);
        checks++;
        if (g !== -1) begin
            failures++;
            $display("FAIL strict_priority gnt_cycle=%0d expected never", g + 1);
        end
        core_req = 1'b0;
        wait_for_gnt(5, g);
        checks++;
        if (g !== 1) begin
            failures++;
            $display("FAIL idle_grant gnt_cycle=%0d expected=1", g);
        end
`endif
        host_req = 1'b0; host_last = 1'b0; core_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_stall_in_host();
        int g;
        host_req = 1'b1; host_we = 1'b0; host_addr = 32'h108; host_last = 1'b1;
        core_req = 1'b0;
        @(posedge clk); #1;
        core_req = 1'b1; core_addr = 32'h40;
        wait_for_gnt(3, g);
        checks++;
        if (g !== 0) begin
            failures++;
            $display("FAIL stall_grant gnt_cycle=%0d expected=0", g);
        end
        host_req = 1'b0; host_last = 1'b0;
        @(negedge clk);
        checks++;
        if (core_stall !== 1'b0 || host_gnt !== 1'b0) begin
            failures++;
            $display("FAIL stall_release stall=%b gnt=%b expected 0 0", core_stall, host_gnt);
        end
        core_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_core_priority();
        int fr, tot, fg;
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h40; core_wdata = 32'h55;
        host_req = 1'b1; host_we = 1'b1; host_addr = 32'h80; host_wdata = 32'h99; host_last = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wd !== 32'h55 || host_gnt !== 1'b0) begin
            failures++;
            $display("FAIL core_store we=%b addr=%h wd=%h gnt=%b expected 1 00000040 00000055 0", mem_we, mem_addr, mem_wd, host_gnt);
        end
        ref_mem[8'h10] = 32'h55;
        @(posedge clk); #1;
        host_req = 1'b0; host_last = 1'b0; host_we = 1'b0;
        core_we = 1'b0;
        @(negedge clk);
        checks++;
        if (core_rdata !== 32'h55) begin
            failures++;
            $display("FAIL core_readback got=%h expected=00000055", core_rdata);
        end
        @(posedge clk); #1;
        core_req = 1'b0;
        host_burst(1'b0, 32'h40, 32'h0, 1, 1'b1, fr, tot, fg);
        host_burst(1'b0, 32'h80, 32'h0, 1, 1'b1, fr, tot, fg);
        @(posedge clk); #1;
    endtask

    task automatic test_forced_release();
        int fr, tot, fg;
        host_burst(1'b1, 32'h200, 32'hB00, 20, 1'b0, fr, tot, fg);
        checks++;
        if (fr !== MAX_BURST || tot !== 20) begin
            failures++;
            $display("FAIL forced_release_write run=%0d beats=%0d expected %0d 20", fr, tot, MAX_BURST);
        end
        @(posedge clk); #1;
        host_burst(1'b0, 32'h200, 32'h0, 20, 1'b1, fr, tot, fg);
        checks++;
        if (fr !== MAX_BURST || tot !== 20) begin
            failures++;
            $display("FAIL forced_release_read run=%0d beats=%0d expected %0d 20", fr, tot, MAX_BURST);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abandon();
        int fr, tot, fg;
        host_burst(1'b1, 32'h300, 32'hC0, 2, 1'b0, fr, tot, fg);
        @(negedge clk);
        checks++;
        if (host_gnt !== 1'b1 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL abandon_cycle gnt=%b we=%b expected 1 0", host_gnt, mem_we);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (host_gnt !== 1'b0) begin
            failures++;
            $display("FAIL abandon_exit gnt=%b expected=0", host_gnt);
        end
        @(posedge clk); #1;
        host_burst(1'b1, 32'h340, 32'hD0, 18, 1'b0, fr, tot, fg);
        checks++;
        if (fr !== MAX_BURST || tot !== 18) begin
            failures++;
            $display("FAIL beat_cnt_cleared run=%0d beats=%0d expected %0d 18", fr, tot, MAX_BURST);
        end
        @(posedge clk); #1;
        host_burst(1'b0, 32'h300, 32'h0, 2, 1'b1, fr, tot, fg);
        host_burst(1'b0, 32'h378, 32'h0, 4, 1'b1, fr, tot, fg);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; host_last = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'h1000_0000 + 32'(i);
            ref_mem[i] = 32'h1000_0000 + 32'(i);
        end
        test_reset();
        test_write_burst();
        test_contention();
        test_stall_in_host();
        test_core_priority();
        test_forced_release();
        test_abandon();
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL pending_reads left=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
